// File: rtl/fp_addsub_align_add.sv
`default_nettype none
// ============================================================================
//  Module   : fp_addsub_align_add
//  Brief    : Single-precision add/sub pipeline, stages 2 and 3.
//             Stage 2 orders operands by magnitude and aligns the smaller
//             significand with guard/round/sticky collection. Stage 3 does
//             the effective add/subtract and reports the leading-zero count
//             consumed by the normalize/round stage.
//  Revision : 1.0  initial release
// ============================================================================
module fp_addsub_align_add (
   input  logic        clk,
   input  logic        rst,
   input  logic        s1_valid_data_in,
   input  logic [31:0] s1_in1,
   input  logic [31:0] s1_in2,
   input  logic [2:0]  s1_rounding_mode,
   input  logic        s1_special_case,
   input  logic [31:0] s1_special_result,
   input  logic        s1_input_is_invalid,
   input  logic        s1_input_is_flushed,
   output logic        s3_valid,
   output logic        s3_sign,
   output logic [7:0]  s3_exponent,
   output logic [27:0] s3_sum,
   output logic [4:0]  s3_lzc,
   output logic        s3_exact_zero,
   output logic        s3_special_case,
   output logic [31:0] s3_special_result,
   output logic        s3_invalid,
   output logic        s3_flushed,
   output logic [2:0]  s3_rounding_mode
);

   // Round-toward-negative encoding; an exact zero difference takes sign 1 here.
   localparam logic [2:0] RM_RDN = 3'b010;

   // ------------------------------------------------------------------------
   // Stage 2 combinational: ordering and alignment
   // ------------------------------------------------------------------------
   logic        swap;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [26:0] sig_a;
   logic [26:0] sig_b;
   logic [7:0]  exp_diff;
   logic [26:0] b_shift;
   logic [26:0] shift_mask;
   logic        sticky;
   logic [26:0] b_aligned;

   // Pick the larger magnitude as A (tie keeps in1), then shift B right by the
   // exponent difference, folding every bit shifted out into the sticky bit.
   always_comb begin
      swap       = s1_in2[30:0] > s1_in1[30:0];
      op_a       = swap ? s1_in2 : s1_in1;
      op_b       = swap ? s1_in1 : s1_in2;
      sig_a      = {1'b1, op_a[22:0], 3'b000};
      sig_b      = {1'b1, op_b[22:0], 3'b000};
      exp_diff   = op_a[30:23] - op_b[30:23];
      b_shift    = sig_b >> exp_diff;
      shift_mask = ~({27{1'b1}} << exp_diff);
      sticky     = |(sig_b & shift_mask);
      if (exp_diff < 8'd27) begin
         b_aligned = {b_shift[26:1], b_shift[0] | sticky};
      end else begin
         // Whole significand is below the sticky position.
         b_aligned = 27'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Stage 2 registers
   // ------------------------------------------------------------------------
   logic        s2_valid;
   logic [26:0] s2_sig_a;
   logic [26:0] s2_b_aligned;
   logic [7:0]  s2_exp_a;
   logic        s2_sign_a;
   logic        s2_eff_sub;
   logic [2:0]  s2_rounding_mode;
   logic        s2_special_case;
   logic [31:0] s2_special_result;
   logic        s2_invalid;
   logic        s2_flushed;

   // Capture aligned operands and pass-through fields every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid          <= 1'b0;
         s2_sig_a          <= 27'd0;
         s2_b_aligned      <= 27'd0;
         s2_exp_a          <= 8'd0;
         s2_sign_a         <= 1'b0;
         s2_eff_sub        <= 1'b0;
         s2_rounding_mode  <= 3'd0;
         s2_special_case   <= 1'b0;
         s2_special_result <= 32'd0;
         s2_invalid        <= 1'b0;
         s2_flushed        <= 1'b0;
      end else begin
         s2_valid          <= s1_valid_data_in;
         s2_sig_a          <= sig_a;
         s2_b_aligned      <= b_aligned;
         s2_exp_a          <= op_a[30:23];
         s2_sign_a         <= op_a[31];
         s2_eff_sub        <= s1_in1[31] ^ s1_in2[31];
         s2_rounding_mode  <= s1_rounding_mode;
         s2_special_case   <= s1_special_case;
         s2_special_result <= s1_special_result;
         s2_invalid        <= s1_input_is_invalid;
         s2_flushed        <= s1_input_is_flushed;
      end
   end

   // ------------------------------------------------------------------------
   // Stage 3 combinational: add/subtract and leading-zero count
   // ------------------------------------------------------------------------
   logic [27:0] sum;
   logic [4:0]  lzc;
   logic        sum_is_zero;

   // A >= B in magnitude, so the subtraction never goes negative.
   always_comb begin
      if (s2_eff_sub) begin
         sum = {1'b0, s2_sig_a} - {1'b0, s2_b_aligned};
      end else begin
         sum = {1'b0, s2_sig_a} + {1'b0, s2_b_aligned};
      end
      sum_is_zero = (sum == 28'd0);
   end

   // Scan upward; the highest set bit is the last to write, giving its count.
   always_comb begin
      lzc = 5'd28;
      for (int i = 0; i < 28; i++) begin
         if (sum[i]) begin
            lzc = 5'(27 - i);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stage 3 registers; datapath forced to zero for resolved special cases
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s3_valid          <= 1'b0;
         s3_sign           <= 1'b0;
         s3_exponent       <= 8'd0;
         s3_sum            <= 28'd0;
         s3_lzc            <= 5'd0;
         s3_exact_zero     <= 1'b0;
         s3_special_case   <= 1'b0;
         s3_special_result <= 32'd0;
         s3_invalid        <= 1'b0;
         s3_flushed        <= 1'b0;
         s3_rounding_mode  <= 3'd0;
      end else begin
         s3_valid          <= s2_valid;
         s3_special_case   <= s2_special_case;
         s3_special_result <= s2_special_result;
         s3_invalid        <= s2_invalid;
         s3_flushed        <= s2_flushed;
         s3_rounding_mode  <= s2_rounding_mode;
         if (s2_special_case) begin
            s3_sign       <= 1'b0;
            s3_exponent   <= 8'd0;
            s3_sum        <= 28'd0;
            s3_lzc        <= 5'd0;
            s3_exact_zero <= 1'b0;
         end else begin
            s3_sign       <= sum_is_zero ? (s2_rounding_mode == RM_RDN) : s2_sign_a;
            s3_exponent   <= s2_exp_a;
            s3_sum        <= sum;
            s3_lzc        <= lzc;
            s3_exact_zero <= sum_is_zero;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_align_add.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_addsub_align_add
//  Brief    : Scoreboard bench for fp_addsub_align_add stages 2/3.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_addsub_align_add;

   logic        clk;
   logic        rst;
   logic        s1_valid_data_in;
   logic [31:0] s1_in1;
   logic [31:0] s1_in2;
   logic [2:0]  s1_rounding_mode;
   logic        s1_special_case;
   logic [31:0] s1_special_result;
   logic        s1_input_is_invalid;
   logic        s1_input_is_flushed;
   logic        s3_valid;
   logic        s3_sign;
   logic [7:0]  s3_exponent;
   logic [27:0] s3_sum;
   logic [4:0]  s3_lzc;
   logic        s3_exact_zero;
   logic        s3_special_case;
   logic [31:0] s3_special_result;
   logic        s3_invalid;
   logic        s3_flushed;
   logic [2:0]  s3_rounding_mode;

   fp_addsub_align_add dut (
      .clk                 (clk),
      .rst                 (rst),
      .s1_valid_data_in    (s1_valid_data_in),
      .s1_in1              (s1_in1),
      .s1_in2              (s1_in2),
      .s1_rounding_mode    (s1_rounding_mode),
      .s1_special_case     (s1_special_case),
      .s1_special_result   (s1_special_result),
      .s1_input_is_invalid (s1_input_is_invalid),
      .s1_input_is_flushed (s1_input_is_flushed),
      .s3_valid            (s3_valid),
      .s3_sign             (s3_sign),
      .s3_exponent         (s3_exponent),
      .s3_sum              (s3_sum),
      .s3_lzc              (s3_lzc),
      .s3_exact_zero       (s3_exact_zero),
      .s3_special_case     (s3_special_case),
      .s3_special_result   (s3_special_result),
      .s3_invalid          (s3_invalid),
      .s3_flushed          (s3_flushed),
      .s3_rounding_mode    (s3_rounding_mode)
   );

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RDN = 3'b010;

   typedef struct {
      logic        sign;
      logic [7:0]  exp;
      logic [27:0] sum;
      logic [4:0]  lzc;
      logic        ez;
      logic        sc;
      logic [31:0] sr;
      logic        inv;
      logic        fl;
      logic [2:0]  rm;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   n_chk;
   int   n_err;
   int   cyc;
   int   valid_seen;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, req, cyc);
      end
   endtask

   function automatic exp_t mk(input logic sign, input logic [7:0] exp, input logic [27:0] sum,
                               input logic [4:0] lzc, input logic ez, input logic [2:0] rm,
                               input logic sc, input logic [31:0] sr, input logic inv,
                               input logic fl);
      exp_t e;
      e.sign = sign; e.exp = exp; e.sum = sum; e.lzc = lzc; e.ez = ez;
      e.rm = rm; e.sc = sc; e.sr = sr; e.inv = inv; e.fl = fl; e.cyc = 0;
      return e;
   endfunction

   // Reference: wide-window alignment, sticky taken from bits below the window.
   function automatic exp_t model(input logic [31:0] in1, input logic [31:0] in2,
                                  input logic [2:0] rm, input logic sc, input logic [31:0] sr,
                                  input logic inv, input logic fl);
      exp_t        e;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] w;
      logic [26:0] sa;
      logic [26:0] bal;
      logic [27:0] s;
      int          d;
      int          n;
      e = mk(1'b0, 8'd0, 28'd0, 5'd0, 1'b0, rm, sc, sr, inv, fl);
      if (sc) return e;
      if (in2[30:0] > in1[30:0]) begin a = in2; b = in1; end
      else begin a = in1; b = in2; end
      d  = int'(a[30:23]) - int'(b[30:23]);
      sa = {1'b1, a[22:0], 3'b000};
      w  = {37'd0, 1'b1, b[22:0], 3'b000} << 36;
      if (d >= 27) begin
         bal = 27'd1;
      end else begin
         w   = w >> d;
         bal = w[62:36];
         if (w[35:0] != 36'd0) bal[0] = 1'b1;
      end
      s = (a[31] ^ b[31]) ? ({1'b0, sa} - {1'b0, bal}) : ({1'b0, sa} + {1'b0, bal});
      n = 0;
      while (n < 28 && s[27-n] == 1'b0) n++;
      e.sum  = s;
      e.lzc  = 5'(n);
      e.ez   = (s == 28'd0);
      e.sign = e.ez ? (rm == RM_RDN) : a[31];
      e.exp  = a[30:23];
      return e;
   endfunction

   task automatic send(input logic [31:0] in1, input logic [31:0] in2, input logic [2:0] rm,
                       input logic sc, input logic [31:0] sr, input logic inv, input logic fl,
                       input exp_t e);
      @(negedge clk);
      s1_valid_data_in    = 1'b1;
      s1_in1              = in1;
      s1_in2              = in2;
      s1_rounding_mode    = rm;
      s1_special_case     = sc;
      s1_special_result   = sr;
      s1_input_is_invalid = inv;
      s1_input_is_flushed = fl;
      e.cyc = cyc + 2;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         s1_valid_data_in    = 1'b0;
         s1_in1              = $urandom;
         s1_in2              = $urandom;
         s1_rounding_mode    = 3'($urandom_range(0, 4));
         s1_special_case     = 1'($urandom_range(0, 1));
         s1_special_result   = $urandom;
         s1_input_is_invalid = 1'($urandom_range(0, 1));
         s1_input_is_flushed = 1'($urandom_range(0, 1));
      end
   endtask

   // Output monitor: every valid output must match the oldest pending entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && s3_valid) begin
            valid_seen++;
            if (q.size() == 0) begin
               check("unexpected_valid", 32'(s3_valid), 32'd0);
            end else begin
               e = q.pop_front();
               check("latency_cycle", 32'(cyc),              32'(e.cyc));
               check("sign",          32'(s3_sign),          32'(e.sign));
               check("exponent",      32'(s3_exponent),      32'(e.exp));
               check("sum",           32'(s3_sum),           32'(e.sum));
               check("lzc",           32'(s3_lzc),           32'(e.lzc));
               check("exact_zero",    32'(s3_exact_zero),    32'(e.ez));
               check("special_case",  32'(s3_special_case),  32'(e.sc));
               check("special_res",   s3_special_result,     e.sr);
               check("invalid",       32'(s3_invalid),       32'(e.inv));
               check("flushed",       32'(s3_flushed),       32'(e.fl));
               check("rounding_mode", 32'(s3_rounding_mode), 32'(e.rm));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, pending=%0d", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  rm;
      logic        sc;
      int          ea;
      int          eb;
      int          seen_before;
      n_chk = 0; n_err = 0; cyc = 0; valid_seen = 0;
      rst = 1'b1;
      s1_valid_data_in = 1'b0; s1_in1 = 32'd0; s1_in2 = 32'd0; s1_rounding_mode = 3'd0;
      s1_special_case = 1'b0; s1_special_result = 32'd0;
      s1_input_is_invalid = 1'b0; s1_input_is_flushed = 1'b0;

      // Reset state
      #1;
      check("rst_valid",       32'(s3_valid),       32'd0);
      check("rst_sum",         32'(s3_sum),         32'd0);
      check("rst_special_res", s3_special_result,   32'd0);
      check("rst_exponent",    32'(s3_exponent),    32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      // Directed cases
      send(32'h3F800000, 32'h3F800000, RM_RNE, 1'b0, 32'd0, 1'b0, 1'b0,
           mk(1'b0, 8'h7F, 28'h8000000, 5'd0, 1'b0, RM_RNE, 1'b0, 32'd0, 1'b0, 1'b0));
      send(32'h3F800000, 32'hBF800000, RM_RNE, 1'b0, 32'd0, 1'b0, 1'b0,
           mk(1'b0, 8'h7F, 28'h0, 5'd28, 1'b1, RM_RNE, 1'b0, 32'd0, 1'b0, 1'b0));
      send(32'h3F800000, 32'hBF800000, RM_RDN, 1'b0, 32'd0, 1'b0, 1'b0,
           mk(1'b1, 8'h7F, 28'h0, 5'd28, 1'b1, RM_RDN, 1'b0, 32'd0, 1'b0, 1'b0));
      send(32'h4B800000, 32'h3F800000, RM_RNE, 1'b0, 32'd0, 1'b0, 1'b0,
           mk(1'b0, 8'h97, 28'h4000004, 5'd1, 1'b0, RM_RNE, 1'b0, 32'd0, 1'b0, 1'b0));
      idle(1);
      send(32'h4E000000, 32'h3F800000, RM_RNE, 1'b0, 32'd0, 1'b0, 1'b0,
           mk(1'b0, 8'h9C, 28'h4000001, 5'd1, 1'b0, RM_RNE, 1'b0, 32'd0, 1'b0, 1'b0));
      send(32'h3FC00000, 32'hBF800000, RM_RNE, 1'b0, 32'd0, 1'b0, 1'b0,
           mk(1'b0, 8'h7F, 28'h2000000, 5'd2, 1'b0, RM_RNE, 1'b0, 32'd0, 1'b0, 1'b0));
      send(32'hBF800000, 32'h3FC00000, RM_RNE, 1'b0, 32'd0, 1'b0, 1'b0,
           mk(1'b0, 8'h7F, 28'h2000000, 5'd2, 1'b0, RM_RNE, 1'b0, 32'd0, 1'b0, 1'b0));
      idle(3);

      // Back-to-back stream with a special case in second place
      send(32'h3F800000, 32'h3F800000, 3'b001, 1'b0, 32'd0, 1'b0, 1'b0,
           mk(1'b0, 8'h7F, 28'h8000000, 5'd0, 1'b0, 3'b001, 1'b0, 32'd0, 1'b0, 1'b0));
      send(32'h40000000, 32'h3F800000, 3'b011, 1'b1, 32'h7FC00000, 1'b1, 1'b0,
           mk(1'b0, 8'h00, 28'h0, 5'd0, 1'b0, 3'b011, 1'b1, 32'h7FC00000, 1'b1, 1'b0));
      send(32'h3FC00000, 32'hBF800000, RM_RDN, 1'b0, 32'd0, 1'b0, 1'b1,
           mk(1'b0, 8'h7F, 28'h2000000, 5'd2, 1'b0, RM_RDN, 1'b0, 32'd0, 1'b0, 1'b1));
      send(32'hCB800000, 32'hBF800000, 3'b100, 1'b0, 32'd0, 1'b1, 1'b1,
           mk(1'b1, 8'h97, 28'h4000004, 5'd1, 1'b0, 3'b100, 1'b0, 32'd0, 1'b1, 1'b1));
      idle(3);

      // Random operands with nearby exponents, checked against the reference
      for (int i = 0; i < 40; i++) begin
         ea = $urandom_range(100, 150);
         eb = ea + $urandom_range(0, 34) - 17;
         a  = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
         b  = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
         if (i % 7 == 3) b = {~a[31], a[30:0]};
         rm = 3'($urandom_range(0, 4));
         sc = ($urandom_range(0, 9) == 0);
         send(a, b, rm, sc, 32'h7F800000 | 32'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              model(a, b, rm, sc, 32'h7F800000 | 32'd0, 1'b0, 1'b0));
         // Rebuild the pushed entry with the flags actually driven.
         q[q.size()-1] = model(a, b, rm, sc, s1_special_result,
                               s1_input_is_invalid, s1_input_is_flushed);
         q[q.size()-1].cyc = cyc + 2;
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(4);
      check("drain_empty", 32'(q.size()), 32'd0);

      // Reset with two operations in flight
      seen_before = valid_seen;
      send(32'h3F800000, 32'h3F800000, RM_RNE, 1'b0, 32'd0, 1'b1, 1'b1,
           mk(1'b0, 8'h7F, 28'h8000000, 5'd0, 1'b0, RM_RNE, 1'b0, 32'd0, 1'b1, 1'b1));
      send(32'h3FC00000, 32'h3F800000, RM_RNE, 1'b1, 32'h7FC00000, 1'b1, 1'b1,
           mk(1'b0, 8'h00, 28'h0, 5'd0, 1'b0, RM_RNE, 1'b1, 32'h7FC00000, 1'b1, 1'b1));
      #2;
      rst = 1'b1;
      q.delete();
      #1;
      check("midrst_valid",       32'(s3_valid),          32'd0);
      check("midrst_sum",         32'(s3_sum),            32'd0);
      check("midrst_exponent",    32'(s3_exponent),       32'd0);
      check("midrst_flags",       32'({s3_invalid, s3_flushed, s3_special_case}), 32'd0);
      check("midrst_special_res", s3_special_result,      32'd0);
      @(negedge clk);
      rst = 1'b0;
      s1_valid_data_in = 1'b0;
      idle(6);
      check("post_rst_valids", 32'(valid_seen - seen_before), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
